// File: rtl/otter_fetch_pkg.sv
// Shared types for the OTTER instruction fetch unit.
//   fetch_state_t : fetch FSM states (IDLE, REQ, WAIT, DROP)
//   fetch_entry_t : one fetched entry, {pc, instr, misalign}, 32-bit PC/instr
//   NOP_INSTR     : canonical RV32I no-op (addi x0,x0,0)
package otter_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular output buffer between the fetch FSM and decode.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   flush_i          drop all entries this edge (wins over a concurrent pop)
//   push_i, data_i   append one entry (caller guarantees a free slot)
//   pop_i            remove head; ignored when empty
//   head_o           head entry, all zeros when empty
//   count_o, empty_o occupancy
module fetch_buffer
  import otter_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = $bits(fetch_entry_t)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int IDX_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinct.
  logic [IDX_W:0] wr_q, rd_q;
  logic [W-1:0]   mem_q [DEPTH];

  assign count_o = wr_q - rd_q;
  assign empty_o = (count_o == '0);
  assign head_o  = empty_o ? '0 : mem_q[rd_q[IDX_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i)             wr_q <= wr_q + 1'b1;
      if (pop_i && !empty_o)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !rst_i && !flush_i) mem_q[wr_q[IDX_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// OTTER instruction fetch unit: samples PC_CNT, issues one outstanding imem
// read, buffers {pc, instr} for decode and pulses pc_write when a fetch lands.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned PC pushes a
// flagged entry instead of issuing a read).
// Ports:
//   fetch_clk, fetch_rst              clock, synchronous active-high reset
//   PC_CNT, pc_write                  PC register value in, advance pulse out
//   imem_req/addr/ack/rvalid/rdata    instruction memory read port
//   fetch_flush                       redirect: discard buffer and in-flight
//   if_valid/ready/pc/instr/misalign  decode handshake, head of buffer
module instr_fetch_unit
  import otter_fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              fetch_clk,
  input  logic              fetch_rst,
  input  logic [ADDR_W-1:0] PC_CNT,
  output logic              pc_write,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              fetch_flush,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_misalign
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              misalign;
  } entry_t;

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              push, pop, buf_empty;
  entry_t            push_entry, head;
  logic [CNT_W-1:0]  count;
  logic              pc_mis;
  logic [ADDR_W-1:0] pc_aligned;

  // Without the trap the low PC bits are simply dropped on the address.
  assign pc_aligned = PC_CNT & ~ADDR_W'(3);
  assign pc_mis     = TRAP_EN && (PC_CNT[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    push       = 1'b0;
    pc_write   = 1'b0;
    push_entry = '0;
    case (state_q)
      IDLE: begin
        // count < BUF_DEPTH reserves a slot for the read about to be issued.
        if (!fetch_flush && (count < CNT_W'(BUF_DEPTH))) begin
          if (pc_mis) begin
            push                = 1'b1;
            pc_write            = 1'b1;
            push_entry.pc       = PC_CNT;
            push_entry.misalign = 1'b1;
          end else begin
            state_d = REQ;
            addr_d  = pc_aligned;
          end
        end
      end
      REQ: begin
        if (imem_ack)         state_d = fetch_flush ? DROP : WAIT;
        else if (fetch_flush) state_d = IDLE;
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = IDLE;
          if (!fetch_flush) begin
            push             = 1'b1;
            pc_write         = 1'b1;
            push_entry.pc    = addr_q;
            push_entry.instr = imem_rdata;
          end
        end else if (fetch_flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset must not leak a combinational push/pc_write out of a stale state.
    if (fetch_rst) begin
      push     = 1'b0;
      pc_write = 1'b0;
    end
  end

  always_ff @(posedge fetch_clk) begin
    if (fetch_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign pop = if_valid && if_ready;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .W     ($bits(entry_t))
  ) u_buf (
    .clk_i   (fetch_clk),
    .rst_i   (fetch_rst),
    .flush_i (fetch_flush),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .empty_o (buf_empty)
  );

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = addr_q;
  assign if_valid    = !buf_empty;
  assign if_pc       = head.pc;
  assign if_instr    = head.instr;
  assign if_misalign = head.misalign & TRAP_EN;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ack, rvalid, flush, rdy;
  logic [31:0] pc_cnt, rdata;
  logic        pc_write, imem_req, if_valid, if_misalign;
  logic [31:0] imem_addr, if_pc, if_instr;

  always #5 clk = ~clk;

  instr_fetch_unit #(.BUF_DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .fetch_clk   (clk),
    .fetch_rst   (rst),
    .PC_CNT      (pc_cnt),
    .pc_write    (pc_write),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (ack),
    .imem_rvalid (rvalid),
    .imem_rdata  (rdata),
    .fetch_flush (flush),
    .if_valid    (if_valid),
    .if_ready    (rdy),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_misalign (if_misalign)
  );

  int vectors = 0;
  int miscompares = 0;
  int pcw_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Buffer is a queue of fetched entries; the outstanding read is tracked as
  // "none / being offered / accepted, data wanted / accepted, data unwanted".
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;
  typedef enum int {T_NONE, T_OFFER, T_WANT, T_UNWANTED} txn_t;

  ent_t        mq[$];
  txn_t        txn = T_NONE;
  logic [31:0] m_addr = 32'h0;
  ent_t        e;
  bit          do_push, had_head;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_pc_write", {31'b0, pc_write}, 32'h0);
      mq.delete();
      txn = T_NONE;
    end else begin
      if (pc_write) pcw_count++;
      had_head = (mq.size() > 0);
      chk("imem_req", {31'b0, imem_req}, {31'b0, txn == T_OFFER});
      if (txn == T_OFFER) chk("imem_addr", imem_addr, m_addr);
      chk("if_valid", {31'b0, if_valid}, {31'b0, had_head});
      chk("if_pc", if_pc, had_head ? mq[0].pc : 32'h0);
      chk("if_instr", if_instr, had_head ? mq[0].instr : 32'h0);
      chk("if_misalign", {31'b0, if_misalign}, {31'b0, had_head ? mq[0].mis : 1'b0});
      do_push = 1'b0;
      case (txn)
        T_NONE:
          if (!flush && mq.size() < DEPTH) begin
            if (TRAP && pc_cnt[1:0] != 2'b00) begin
              do_push = 1'b1;
              e = '{pc: pc_cnt, instr: 32'h0, mis: 1'b1};
            end else begin
              txn = T_OFFER;
              m_addr = {pc_cnt[31:2], 2'b00};
            end
          end
        T_OFFER:
          if (ack) txn = flush ? T_UNWANTED : T_WANT;
          else if (flush) txn = T_NONE;
        T_WANT:
          if (rvalid) begin
            txn = T_NONE;
            if (!flush) begin
              do_push = 1'b1;
              e = '{pc: m_addr, instr: rdata, mis: 1'b0};
            end
          end else if (flush) txn = T_UNWANTED;
        T_UNWANTED:
          if (rvalid) txn = T_NONE;
        default: txn = T_NONE;
      endcase
      chk("pc_write", {31'b0, pc_write}, {31'b0, do_push});
      if (flush) mq.delete();
      else begin
        if (had_head && rdy) void'(mq.pop_front());
        if (do_push) mq.push_back(e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk("wait_req_timeout", {31'b0, imem_req}, 32'h1);
  endtask

  // Accept the pending request now; data returns lat cycles after the ack.
  task automatic serve(input int lat, input logic [31:0] data);
    ack = 1'b1;
    step();
    ack = 1'b0;
    repeat (lat - 1) step();
    rvalid = 1'b1;
    rdata  = data;
    step();
    rvalid = 1'b0;
    rdata  = 32'h0;
  endtask

  int pcw0;

  initial begin
    rst = 1'b1; ack = 1'b0; rvalid = 1'b0; flush = 1'b0; rdy = 1'b0;
    pc_cnt = 32'h0; rdata = 32'h0;
    repeat (3) step();
    chk("reset_if_valid", {31'b0, if_valid}, 32'h0);
    chk("reset_imem_req", {31'b0, imem_req}, 32'h0);
    chk("reset_imem_addr", imem_addr, 32'h0);
    chk("reset_if_pc", if_pc, 32'h0);

    // Single fetch, ack at once, data 2 cycles later
    pc_cnt = 32'h100;
    rst = 1'b0;
    pcw0 = pcw_count;
    wait_req();
    chk("t2_addr", imem_addr, 32'h100);
    serve(2, 32'h0050_0093);
    chk("t2_if_valid", {31'b0, if_valid}, 32'h1);
    chk("t2_if_pc", if_pc, 32'h100);
    chk("t2_if_instr", if_instr, 32'h0050_0093);
    chk("t2_pcw_pulses", pcw_count - pcw0, 32'd1);
    pc_cnt = 32'h104;

    // Decode stalled: buffer fills, issue stops until a pop frees a slot
    wait_req();
    chk("t3_addr2", imem_addr, 32'h104);
    serve(1, 32'h0010_8113);
    pc_cnt = 32'h108;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_no_3rd_req", {31'b0, imem_req}, 32'h0);
    end
    chk("t3_head_pc", if_pc, 32'h100);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    chk("t3_req_after_pop", {31'b0, imem_req}, 32'h0);
    step();
    chk("t3_req_issued", {31'b0, imem_req}, 32'h1);
    chk("t3_addr3", imem_addr, 32'h108);
    chk("t3_head_pc2", if_pc, 32'h104);
    serve(3, 32'h0021_0193);
    pc_cnt = 32'h10C;
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    wait_req();
    chk("t4_addr", imem_addr, 32'h10C);

    // Flush in the same cycle as rvalid (and a concurrent pop)
    pcw0 = pcw_count;
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; flush = 1'b1; rdy = 1'b1; pc_cnt = 32'h200;
    step();
    rvalid = 1'b0; rdata = 32'h0; flush = 1'b0; rdy = 1'b0;
    chk("t4_pcw_none", pcw_count - pcw0, 32'd0);
    chk("t4_if_valid", {31'b0, if_valid}, 32'h0);
    step();
    chk("t4_req", {31'b0, imem_req}, 32'h1);
    chk("t4_new_addr", imem_addr, 32'h200);

    // Flush in WAIT, a second flush while dropping, rvalid 3 cycles later
    pcw0 = pcw_count;
    ack = 1'b1;
    step();
    ack = 1'b0;
    flush = 1'b1; pc_cnt = 32'h300;
    step();
    step();
    flush = 1'b0;
    step();
    rvalid = 1'b1; rdata = 32'h1234_5678;
    step();
    rvalid = 1'b0; rdata = 32'h0;
    chk("t5_pcw_none", pcw_count - pcw0, 32'd0);
    chk("t5_if_valid", {31'b0, if_valid}, 32'h0);
    chk("t5_idle", {31'b0, imem_req}, 32'h0);
    step();
    chk("t5_req_addr", imem_addr, 32'h300);
    serve(1, 32'h00A0_0113);
    chk("t5_if_pc", if_pc, 32'h300);
    chk("t5_if_instr", if_instr, 32'h00A0_0113);
    chk("t5_pcw_one", pcw_count - pcw0, 32'd1);
    pc_cnt = 32'h304;

    // Request withdrawn by a flush before ack
    wait_req();
    chk("wd_addr", imem_addr, 32'h304);
    flush = 1'b1; pc_cnt = 32'h400;
    step();
    flush = 1'b0;
    chk("wd_if_valid", {31'b0, if_valid}, 32'h0);
    chk("wd_req_dropped", {31'b0, imem_req}, 32'h0);
    step();
    chk("wd_new_addr", imem_addr, 32'h400);

    // Reset while waiting for data; data shows up right after
    pcw0 = pcw_count;
    ack = 1'b1;
    step();
    ack = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    chk("t1_req", {31'b0, imem_req}, 32'h0);
    chk("t1_if_valid", {31'b0, if_valid}, 32'h0);
    step();
    rvalid = 1'b0; rdata = 32'h0;
    chk("t1_pcw_none", pcw_count - pcw0, 32'd0);
    chk("t1_if_valid2", {31'b0, if_valid}, 32'h0);

    // Misaligned PC
    rst = 1'b1;
    step();
    pc_cnt = 32'h102;
    rst = 1'b0;
    pcw0 = pcw_count;
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("t6_no_req", {31'b0, imem_req}, 32'h0);
    chk("t6_if_valid", {31'b0, if_valid}, 32'h1);
    chk("t6_if_pc", if_pc, 32'h102);
    chk("t6_if_instr", if_instr, 32'h0);
    chk("t6_misalign", {31'b0, if_misalign}, 32'h1);
    chk("t6_pcw_one", pcw_count - pcw0, 32'd1);
`else
    chk("t6_req", {31'b0, imem_req}, 32'h1);
    chk("t6_addr_forced", imem_addr, 32'h100);
    chk("t6_misalign0", {31'b0, if_misalign}, 32'h0);
    chk("t6_pcw_none", pcw_count - pcw0, 32'd0);
`endif
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
